// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-RAM load arbiter.
// Optional build macro IMEM_WR_PROTECT_EN is consumed by the interface and top.
package imem_pkg;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_STARVE_MAX = 8;

   // Word index of a fetch address; bits at and above addr_w are masked off.
   function automatic logic [31:0] word_idx(input logic [31:0] fetch_addr,
                                            input int unsigned addr_w);
      logic [31:0] mask;
      mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
      return fetch_addr & mask;
   endfunction

endpackage

// File: rtl/imem_load_arbiter_if.sv
// Fetch, loader and RAM signal bundle for imem_load_arbiter.
// With IMEM_WR_PROTECT_EN defined the bundle also carries ld_err.
interface imem_load_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;

   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

`ifdef IMEM_WR_PROTECT_EN
   logic              ld_err;

   modport master (
      output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_ready, ld_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
      output fetch_gnt, fetch_rvalid, fetch_rdata, ld_ready, ld_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );
`else
   modport master (
      output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
      output fetch_gnt, fetch_rvalid, fetch_rdata, ld_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );
`endif

endinterface

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive cycles the loader has been refused.
// sat stays high until clr; clr has priority over inc.
module imem_starve_cnt #(
   parameter int MAX = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);
   localparam int W = $clog2(MAX + 1);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != W'(MAX))) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == W'(MAX));

endmodule

// File: rtl/imem_load_arbiter.sv
// Single-port instruction RAM arbiter: loader-only BOOT, then fetch-priority RUN.
// IMEM_WR_PROTECT_EN: runtime loader writes are accepted but dropped, flagged on ld_err.
module imem_load_arbiter
   import imem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BOOT_WORDS = 18,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                clk,
   input  logic                reset,
   output logic                cpu_run,
   imem_load_arbiter_if.slave  bus
);
   localparam int BW = $clog2(BOOT_WORDS + 1);

   state_t            state;
   state_t            state_nxt;
   logic [BW-1:0]     boot_cnt;
   logic              ld_acc;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_hold;

`ifndef IMEM_WR_PROTECT_EN
   logic force_ld;
   logic starve_inc;
   logic starve_clr;

   assign starve_inc = (state == RUN) && bus.ld_valid && !ld_acc;
   assign starve_clr = !bus.ld_valid || ld_acc;

   imem_starve_cnt #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .sat   (force_ld)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      ld_acc        = 1'b0;
      bus.fetch_gnt = 1'b0;
      bus.ld_ready  = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
`ifdef IMEM_WR_PROTECT_EN
      bus.ld_err    = 1'b0;
`endif
      if (!reset) begin
         case (state)
            BOOT: begin
               bus.ld_ready = 1'b1;
               if (bus.ld_valid) begin
                  ld_acc        = 1'b1;
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = 1'b1;
                  bus.mem_addr  = bus.ld_addr;
                  bus.mem_wdata = bus.ld_data;
                  if (boot_cnt == BW'(BOOT_WORDS - 1)) begin
                     state_nxt = RUN;
                  end
               end
            end
            RUN: begin
`ifdef IMEM_WR_PROTECT_EN
               if (bus.fetch_req) begin
                  bus.fetch_gnt = 1'b1;
                  bus.mem_en    = 1'b1;
                  bus.mem_addr  = ADDR_W'(word_idx(bus.fetch_addr, ADDR_W));
               end else begin
                  bus.ld_ready = 1'b1;
                  bus.ld_err   = bus.ld_valid;
               end
`else
               if (bus.fetch_req && !force_ld) begin
                  bus.fetch_gnt = 1'b1;
                  bus.mem_en    = 1'b1;
                  bus.mem_addr  = ADDR_W'(word_idx(bus.fetch_addr, ADDR_W));
               end else if (bus.ld_valid) begin
                  ld_acc        = 1'b1;
                  bus.ld_ready  = 1'b1;
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = 1'b1;
                  bus.mem_addr  = bus.ld_addr;
                  bus.mem_wdata = bus.ld_data;
               end
`endif
            end
            default: state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         boot_cnt <= '0;
      end else if ((state == BOOT) && ld_acc) begin
         boot_cnt <= boot_cnt + 1'b1;
      end
   end

   // NOTE: only the read-data holding register is reset; the RAM itself keeps its contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid_q   <= 1'b0;
         rdata_hold <= '0;
      end else begin
         rvalid_q <= bus.fetch_gnt;
         if (rvalid_q) begin
            rdata_hold <= bus.mem_rdata;
         end
      end
   end

   // RAM data arrives the cycle after the grant; outside that cycle the last word is held.
   assign bus.fetch_rvalid = rvalid_q;
   assign bus.fetch_rdata  = rvalid_q ? bus.mem_rdata : rdata_hold;
   assign cpu_run          = (state == RUN);

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Controller and arbiter in front of the single-port instruction RAM.
- Shares the RAM between the fetch stage (reads) and a program-loader port (writes), replacing static image preload.
- Holds the CPU in boot until a fixed number of words is loaded, then gives fetch priority, with starvation relief for runtime loader writes.

Parameters:
ADDR_W, 10, word-address width (1024 instructions)
DATA_W, 32, instruction width
BOOT_WORDS, 18, loader writes required before CPU release (1..2**ADDR_W)
STARVE_MAX, 8, consecutive loader-wait cycles in RUN before the loader is forced through (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fetch_req  in  1  fetch stage requests an instruction read
fetch_addr  in  32  word address (PCF); bits above ADDR_W ignored
fetch_gnt  out  1  read accepted this cycle; low = fetch must stall
fetch_rvalid  out  1  fetch_rdata valid (one cycle after grant)
fetch_rdata  out  DATA_W  instruction word
ld_valid  in  1  loader write request
ld_addr  in  ADDR_W  loader word address
ld_data  in  DATA_W  loader write data
ld_ready  out  1  write accepted when ld_valid & ld_ready
cpu_run  out  1  high once boot complete; gates core PC update
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en & !mem_we

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = BOOT; boot_cnt = 0; starve_cnt = 0
  - cpu_run, fetch_gnt, fetch_rvalid, ld_ready, mem_en, mem_we = 0
  - fetch_rdata, mem_addr, mem_wdata = 0
- RAM ports are combinational from the grant decision; fetch_rvalid and fetch_rdata are registered.
- State BOOT:
  - ld_ready = 1; fetch_gnt = 0; fetch_req ignored.
  - Each accepted write: mem_en = mem_we = 1, mem_addr = ld_addr, mem_wdata = ld_data; boot_cnt++.
  - When the accepted write makes boot_cnt == BOOT_WORDS, go to RUN next cycle. cpu_run rises the same edge.
- State RUN:
  - Fetch has priority.
  - If fetch_req & !force: fetch_gnt = 1, mem read at fetch_addr[ADDR_W-1:0], ld_ready = 0.
  - If ld_valid & (!fetch_req | force): ld_ready = 1, write performed, fetch_gnt = 0.
- Starvation relief:
  - force = (starve_cnt == STARVE_MAX).
  - starve_cnt++ each cycle ld_valid is high but not accepted.
  - starve_cnt clears on any accepted write or when ld_valid is low.
- Read latency: fetch_rvalid = 1 exactly one cycle after fetch_gnt, fetch_rdata = mem_rdata. Otherwise fetch_rvalid = 0 and fetch_rdata holds its last value.
- Idle: no request pending -> mem_en = 0.
- Same-address write and read in one cycle is impossible; only one side is granted per cycle.
- Write-then-read of the same address in consecutive cycles returns the new data (RAM is write-first across cycles).
- Reset mid-operation (any state): returns to BOOT, counters cleared, cpu_run drops. Any in-flight fetch_rvalid is suppressed. RAM contents are not cleared.
- ld_valid low during BOOT: wait indefinitely, no timeout.

Optional Feature:
IMEM_WR_PROTECT_EN
- Defined:
  - In RUN, loader writes are accepted (ld_ready = 1 whenever not fetch-granted) but dropped: mem_we = 0, RAM unchanged.
  - Extra output ld_err pulses high one cycle per dropped write.
  - Starvation logic is removed.
- Undefined: runtime writes behave as described above; no ld_err port.

Decomposition:
- Package imem_pkg:
  - state enum {BOOT, RUN}
  - default ADDR_W, DATA_W, STARVE_MAX
  - function word_idx(fetch_addr) -> ADDR_W slice
- Sub-module imem_starve_cnt: saturating counter with inc/clear inputs and a sat output; instantiated once.

Test Plan:
- Reset, write 18 words (addr 0..17, data 0x2000_0000+i) -> cpu_run rises on the edge after the 18th accept; fetch_gnt stays 0 throughout BOOT even with fetch_req = 1.
- RUN, fetch_req with fetch_addr = 5 -> fetch_gnt = 1, next cycle fetch_rvalid = 1, fetch_rdata = 0x2000_0005.
- RUN, fetch_req held high, ld_valid high at addr 3 -> ld_ready = 0 for 8 cycles, accepted on the 9th; that cycle fetch_gnt = 0; a subsequent read of addr 3 returns new data.
- Fetch addr 0x0000_0405 -> reads index 5 (upper bits ignored).
- Assert reset during RUN mid-fetch -> next cycle fetch_rvalid = 0, cpu_run = 0, state BOOT; a re-boot of 18 writes is required.
- With IMEM_WR_PROTECT_EN, RUN write of 0xDEAD_BEEF to addr 2 -> ld_err pulse; read of addr 2 still returns 0x2000_0002.
